// File: rtl/img_host_if_if.sv
// Core-facing bus of the image host: original-pixel read channel, processed-pixel
// write channel and the core's completion flag.
interface img_host_if_if #(
    parameter int AW = 14,
    parameter int DW = 8
);
    logic          request;
    logic [AW-1:0] orig_addr;
    logic          orig_ready;
    logic [DW-1:0] orig_data;
    logic          imgproc_ready;
    logic [AW-1:0] imgproc_addr;
    logic [DW-1:0] imgproc_data;
    logic          finish;

    modport master (
        output request, orig_addr, imgproc_ready, imgproc_addr, imgproc_data, finish,
        input  orig_ready, orig_data
    );

    modport slave (
        input  request, orig_addr, imgproc_ready, imgproc_addr, imgproc_data, finish,
        output orig_ready, orig_data
    );
endinterface

// File: rtl/img_host_if.sv
// Memory-side partner of the imgproc core: serves original pixels from a host-loaded
// image buffer, captures result pixels with coverage/duplicate tracking, host readback.
module img_host_if #(
    parameter int AW    = 14,
    parameter int DW    = 8,
    parameter int DEPTH = 16384
) (
    input  logic          clk,
    input  logic          rst,
    img_host_if_if.slave  core,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    input  logic          start,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   wr_count,
    output logic [AW:0]   dup_count
);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_MAX = {(AW + 1){1'b1}};
    localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          state_r;
    logic            orig_ready_r;
    logic [DW-1:0]   orig_data_r;
    logic [DW-1:0]   rd_data_r;
    logic            busy_r;
    logic            done_r;
    logic [AW:0]     wr_count_r;
    logic [AW:0]     dup_count_r;
    logic [DEPTH-1:0] written_r;

    logic [DW-1:0]   image_mem_r  [DEPTH];
    logic [DW-1:0]   result_mem_r [DEPTH];

    logic            orig_in_range_s;
    logic            wr_in_range_s;
    logic            rd_in_range_s;
    logic            load_accept_s;
    logic            wr_accept_s;

    // Address range qualification and per-cycle accept strobes.
    always_comb begin
        orig_in_range_s = ({1'b0, core.orig_addr} < DEPTH_L);
        wr_in_range_s   = ({1'b0, core.imgproc_addr} < DEPTH_L);
        rd_in_range_s   = ({1'b0, rd_addr} < DEPTH_L);
        load_accept_s   = (state_r == ST_LOAD) && load_en && ({1'b0, load_addr} < DEPTH_L);
        wr_accept_s     = (state_r == ST_SERVE) && core.imgproc_ready && wr_in_range_s;
    end

    // Pixel storage; contents are kept across reset so a host can reuse a loaded image.
    always_ff @(posedge clk) begin
        if (load_accept_s) begin
            image_mem_r[load_addr] <= load_data;
        end
        if (wr_accept_s) begin
            result_mem_r[core.imgproc_addr] <= core.imgproc_data;
        end
    end

    // Control FSM with registered read/readback outputs and write bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_LOAD;
            orig_ready_r <= 1'b0;
            orig_data_r  <= '0;
            rd_data_r    <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            wr_count_r   <= '0;
            dup_count_r  <= '0;
            written_r    <= '0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    orig_ready_r <= 1'b0;
                    orig_data_r  <= '0;
                    rd_data_r    <= '0;
                    if (start) begin
                        state_r <= ST_SERVE;
                        busy_r  <= 1'b1;
                    end
                end
                ST_SERVE: begin
                    // A request in the finishing cycle is still answered in the first DONE cycle.
                    orig_ready_r <= core.request;
                    orig_data_r  <= (core.request && orig_in_range_s) ?
                                    image_mem_r[core.orig_addr] : '0;
                    rd_data_r    <= '0;
                    if (wr_accept_s) begin
                        if (written_r[core.imgproc_addr]) begin
                            if (dup_count_r != CNT_MAX) begin
                                dup_count_r <= dup_count_r + CNT_ONE;
                            end
                        end else begin
                            written_r[core.imgproc_addr] <= 1'b1;
                            if (wr_count_r != CNT_MAX) begin
                                wr_count_r <= wr_count_r + CNT_ONE;
                            end
                        end
                    end
                    if (core.finish) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    orig_ready_r <= 1'b0;
                    orig_data_r  <= '0;
                    rd_data_r    <= rd_in_range_s ? result_mem_r[rd_addr] : '0;
                end
                default: begin
                    state_r      <= ST_LOAD;
                    orig_ready_r <= 1'b0;
                    orig_data_r  <= '0;
                    rd_data_r    <= '0;
                    busy_r       <= 1'b0;
                    done_r       <= 1'b0;
                end
            endcase
        end
    end

    assign core.orig_ready = orig_ready_r;
    assign core.orig_data  = orig_data_r;
    assign rd_data         = rd_data_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign wr_count        = wr_count_r;
    assign dup_count       = dup_count_r;

endmodule

// File: doc/img_host_if.md
Name: img_host_if

Overview:
- Memory-side counterpart of the imgproc core.
- Serves the core's original-image read requests (request/orig_addr -> orig_ready/orig_data) from an internal image buffer that a host loads beforehand.
- Captures the core's processed-pixel writes (imgproc_ready/addr/data) into a result buffer, tracks coverage and duplicate writes, and exposes the results for host readback once the core signals finish.
- Replaces behavioural pattern/golden arrays in system-level simulation and in FPGA bring-up.

Parameters:
- AW, 14, address width (128x128 image).
- DW, 8, pixel width.
- DEPTH, 16384, number of valid pixel addresses; must be <= 2**AW.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- load_en  in  1  host writes load_data to image buffer at load_addr (LOAD state only).
- load_addr  in  AW  host load address.
- load_data  in  DW  host load pixel.
- start  in  1  single-cycle pulse: LOAD -> SERVE.
- request  in  1  core read request, held with orig_addr.
- orig_addr  in  AW  core read address.
- orig_ready  out  1  read data valid.
- orig_data  out  DW  read pixel; 0 when orig_ready is low.
- imgproc_ready  in  1  core result write strobe.
- imgproc_addr  in  AW  result address.
- imgproc_data  in  DW  result pixel.
- finish  in  1  core completion flag.
- rd_addr  in  AW  host readback address (DONE state).
- rd_data  out  DW  readback pixel, 1-cycle latency.
- busy  out  1  high in SERVE.
- done  out  1  high in DONE.
- wr_count  out  AW+1  distinct addresses written.
- dup_count  out  AW+1  writes to already-written addresses.

Behaviour:
- Reset (rst low, async):
  - State = LOAD.
  - orig_ready, orig_data, rd_data, busy, done, wr_count and dup_count = 0.
  - Written-bitmap (DEPTH bits) cleared.
  - Image and result buffer contents are not reset.
  - Reset mid-SERVE or mid-DONE has the same effect.
- States:
  - LOAD: load_en writes the image buffer. request and imgproc_ready are ignored; orig_ready stays 0. start -> SERVE.
  - SERVE: busy = 1. load_en and start are ignored. A finish sampled high -> DONE on the next edge.
  - DONE: done = 1, terminal until reset. request, imgproc_ready, load_en and start are ignored.
- Read serving (SERVE only):
  - If request is high at edge t, then at edge t+1 orig_ready = 1 and orig_data = image[orig_addr sampled at t].
  - Back-to-back requests give one valid datum per cycle.
  - When request drops, orig_ready and orig_data go to 0 on the next edge.
  - If orig_addr >= DEPTH: orig_ready = 1, orig_data = 0.
- Result capture (SERVE only): when imgproc_ready is high with addr < DEPTH, result[addr] <= data.
  - If the bitmap bit is clear: set it, wr_count++.
  - If the bit is already set: overwrite the result, dup_count++.
  - Both counters saturate at 2**(AW+1)-1.
  - Writes with addr >= DEPTH are dropped and not counted.
- Simultaneous events:
  - imgproc_ready and finish in the same cycle: the write is accepted, then the state goes to DONE.
  - request and finish in the same cycle: the read is still answered in the next cycle (first DONE cycle); nothing further is answered.
  - start together with load_en in LOAD: the load is performed, then the state goes to SERVE.
- Readback (DONE only): rd_data <= result[rd_addr] on each edge. rd_data = 0 outside DONE, and 0 when rd_addr >= DEPTH.
- Address fields are unsigned. No arithmetic on pixel data.

Test Plan:
1. Load image[i] = i[7:0] for all 16384 addresses, start, then request addresses 0, 1, 16383 back-to-back -> orig_ready is high for 3 cycles, each one cycle after its request, with orig_data = 0x00, 0x01, 0xFF. Dropping request -> orig_ready = 0 and orig_data = 0 the next cycle.
2. In LOAD, assert request with orig_addr = 5 -> orig_ready stays 0. Then in SERVE, pulse load_en to addr 5 with data 0xAA -> a read of addr 5 still returns 5.
3. Write results res[a] = ~a[7:0] to all 16384 addresses, then pulse finish -> wr_count = 16384, dup_count = 0, done = 1. rd_addr = 3 returns 0xFC one cycle later.
4. Write addr 7 with 0x11, then addr 7 again with 0x22, finish -> wr_count = 1, dup_count = 1, readback of addr 7 = 0x22.
5. imgproc_ready with addr 9 / 0x33 in the same cycle as finish -> write accepted (wr_count = 1, readback 0x33). A later imgproc_ready is ignored.
6. Drive rst low mid-SERVE after 100 writes -> orig_ready, busy, done, wr_count and dup_count are 0 asynchronously. The state returns to LOAD, and after start a fresh write to the same address counts as new (wr_count = 1, dup_count = 0).
